e_mdu: RTL and testbench

- Multiply/divide unit in the Execute stage of the five-stage MIPS pipeline.
- Holds the architectural HI/LO registers and runs multi-cycle mult/div operations.
- Serves mfhi/mflo reads through MDU_out, which is the value the E/M pipeline register captures as its MDU input.
- Drives busy to the hazard unit, which stalls later MDU instructions in E.

---
 rtl/e_mdu_if.sv | 20 ++
 rtl/e_mdu.sv | 125 ++++++++++++
 tb/tb_e_mdu.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_if.sv
// Execute-stage MDU request/response bundle: pipeline drives the op, MDU returns busy/read data.
interface e_mdu_if;
    logic        en;
    logic        Req;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] MDU_out;

    modport master (
        output en, Req, op, A, B,
        input  busy, MDU_out
    );

    modport slave (
        input  en, Req, op, A, B,
        output busy, MDU_out
    );
endinterface

// File: rtl/e_mdu.sv
// Multiply/divide unit: owns HI/LO, runs fixed-latency mult/div, serves mfhi/mflo reads.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic    clk,
    input logic    reset,
    e_mdu_if.slave bus
);
    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMfhi  = 4'd5;
    localparam logic [3:0] OpMflo  = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
    logic            pend_wr_q, pend_wr_d;

    logic               acc;
    logic [63:0]        prod_s, prod_u;
    logic               div_zero, div_ovf;
    logic signed [31:0] a_s, b_s, q_s, r_s;
    logic [31:0]        divisor, q_u, r_u;

    assign acc = bus.en & ~bus.Req & (state_q == StIdle);

    assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    assign prod_u = {32'b0, bus.A} * {32'b0, bus.B};

    // Substitute divisor 1 on /0 so the dividers never produce X; the result is discarded anyway.
    assign div_zero = (bus.B == 32'd0);
    assign div_ovf  = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);
    assign divisor  = div_zero ? 32'd1 : bus.B;
    assign a_s      = $signed(bus.A);
    assign b_s      = $signed(divisor);
    assign q_s      = div_ovf ? 32'sh8000_0000 : a_s / b_s;
    assign r_s      = div_ovf ? 32'sd0 : a_s % b_s;
    assign q_u      = bus.A / divisor;
    assign r_u      = bus.A % divisor;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        sh_hi_d   = sh_hi_q;
        sh_lo_d   = sh_lo_q;
        pend_wr_d = pend_wr_q;
        unique case (state_q)
            StIdle: begin
                if (acc) begin
                    case (bus.op)
                        OpMult, OpMultu: begin
                            {sh_hi_d, sh_lo_d} = (bus.op == OpMult) ? prod_s : prod_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = CntW'(MULT_CYCLES);
                            state_d   = StBusy;
                        end
                        OpDiv, OpDivu: begin
                            sh_hi_d   = (bus.op == OpDiv) ? r_s : r_u;
                            sh_lo_d   = (bus.op == OpDiv) ? q_s : q_u;
                            pend_wr_d = ~div_zero;
                            cnt_d     = CntW'(DIV_CYCLES);
                            state_d   = StBusy;
                        end
                        OpMthi:  hi_d = bus.A;
                        OpMtlo:  lo_d = bus.A;
                        default: ;
                    endcase
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d   = StIdle;
                    pend_wr_d = 1'b0;
                    if (pend_wr_q) begin
                        hi_d = sh_hi_q;
                        lo_d = sh_lo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            sh_hi_q   <= '0;
            sh_lo_q   <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            sh_hi_q   <= sh_hi_d;
            sh_lo_q   <= sh_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign bus.busy = (state_q == StBusy);

    always_comb begin
        bus.MDU_out = 32'd0;
        if (bus.op == OpMfhi) bus.MDU_out = hi_q;
        else if (bus.op == OpMflo) bus.MDU_out = lo_q;
    end
endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: latency, arithmetic, Req suppression, busy interlock, async reset.
module tb_e_mdu;
    localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   n;

    e_mdu_if bus();

    e_mdu #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [3:0] o, input logic [31:0] exp);
        bus.en = 1'b0;
        bus.op = o;
        #1;
        chk(tag, bus.MDU_out, exp);
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic req);
        bus.en  = 1'b1;
        bus.Req = req;
        bus.op  = o;
        bus.A   = a;
        bus.B   = b;
        tick();
        bus.en  = 1'b0;
        bus.Req = 1'b0;
        bus.op  = NONE;
    endtask

    // Counts samples with busy high; bound keeps a stuck busy from hanging the run.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        bus.en  = 1'b1;
        bus.Req = 1'b0;
        bus.op  = MTHI;
        bus.A   = 32'h1234;
        bus.B   = 32'd0;
        tick();
        tick();
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        rd("reset_hi", MFHI, 32'd0);
        reset = 1'b1;
        tick();
        rd("post_reset_hi", MFHI, 32'd0);
        rd("post_reset_lo", MFLO, 32'd0);
        rd("none_out", NONE, 32'd0);

        issue(MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_idle(n);
        chk("mult_cycles", n, 32'd5);
        rd("mult_hi", MFHI, 32'hFFFF_FFFF);
        rd("mult_lo", MFLO, 32'hFFFF_FFFE);

        issue(MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_idle(n);
        chk("multu_cycles", n, 32'd5);
        rd("multu_hi", MFHI, 32'h0000_0001);
        rd("multu_lo", MFLO, 32'hFFFF_FFFE);

        issue(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle(n);
        chk("div_cycles", n, 32'd10);
        rd("div_lo", MFLO, 32'hFFFF_FFFD);
        rd("div_hi", MFHI, 32'hFFFF_FFFF);

        issue(DIVU, 32'd7, 32'd2, 1'b0);
        wait_idle(n);
        chk("divu_cycles", n, 32'd10);
        rd("divu_lo", MFLO, 32'd3);
        rd("divu_hi", MFHI, 32'd1);

        issue(MTHI, 32'hAA, 32'd0, 1'b0);
        chk("mthi_nobusy", {31'd0, bus.busy}, 32'd0);
        issue(MTLO, 32'hBB, 32'd0, 1'b0);
        rd("mthi_hi", MFHI, 32'hAA);
        issue(DIVU, 32'd50, 32'd0, 1'b0);
        wait_idle(n);
        chk("div0_cycles", n, 32'd10);
        rd("div0_hi", MFHI, 32'hAA);
        rd("div0_lo", MFLO, 32'hBB);

        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle(n);
        rd("ovf_lo", MFLO, 32'h8000_0000);
        rd("ovf_hi", MFHI, 32'd0);

        issue(MTLO, 32'h55, 32'd0, 1'b1);
        rd("req_mtlo_lo", MFLO, 32'h8000_0000);
        issue(MULT, 32'd3, 32'd4, 1'b1);
        chk("req_mult_busy", {31'd0, bus.busy}, 32'd0);
        issue(MULT, 32'd3, 32'd4, 1'b0);
        bus.Req = 1'b1;
        wait_idle(n);
        bus.Req = 1'b0;
        chk("req_inflight_cycles", n, 32'd5);
        rd("req_inflight_lo", MFLO, 32'd12);
        rd("req_inflight_hi", MFHI, 32'd0);

        // Ops presented while busy must be dropped.
        issue(DIVU, 32'd100, 32'd7, 1'b0);
        bus.en = 1'b1;
        bus.op = MTHI;
        bus.A  = 32'h77;
        rd("busy_read_hi", MFHI, 32'd0);
        bus.en = 1'b1;
        bus.op = MTHI;
        tick();
        bus.op = MULT;
        bus.A  = 32'd5;
        bus.B  = 32'd5;
        tick();
        bus.en = 1'b0;
        bus.op = NONE;
        wait_idle(n);
        chk("interlock_cycles", n, 32'd8);
        rd("interlock_hi", MFHI, 32'd2);
        rd("interlock_lo", MFLO, 32'd14);

        // op held through completion: refused on the completing edge, accepted on the next.
        bus.en = 1'b1;
        bus.op = DIVU;
        bus.A  = 32'd9;
        bus.B  = 32'd4;
        for (int i = 0; i < 11; i++) tick();
        chk("held_gap_busy", {31'd0, bus.busy}, 32'd0);
        chk("held_gap_out", bus.MDU_out, 32'd0);
        tick();
        chk("held_restart_busy", {31'd0, bus.busy}, 32'd1);
        bus.en = 1'b0;
        bus.op = NONE;
        wait_idle(n);
        chk("held_restart_cycles", n, 32'd10);
        rd("held_lo", MFLO, 32'd2);
        rd("held_hi", MFHI, 32'd1);

        issue(MULT, 32'd5, 32'd5, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("midop_reset_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("midop_after_busy", {31'd0, bus.busy}, 32'd0);
        rd("midop_hi", MFHI, 32'd0);
        rd("midop_lo", MFLO, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
